// File: rtl/gtxe2_clk_pkg.sv
// Shared types and helpers for the GTXE2 channel rate divider.
// Behaviour of hi_len/div_legal depends on macro GTXE2_RATE_DIV_ODD_EN (odd divisors).
package gtxe2_clk_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } div_state_t;

  localparam int DIV_MIN = 2;
  localparam int FW      = 16;

  // Cycles of the period during which clk_out is high.
  function automatic logic [FW-1:0] hi_len(input logic [FW-1:0] d);
`ifdef GTXE2_RATE_DIV_ODD_EN
    return (d + 16'd1) >> 1;
`else
    return d >> 1;
`endif
  endfunction

  function automatic logic div_legal(input logic [FW-1:0] d);
    if (d < 16'(DIV_MIN)) begin
      return 1'b0;
    end else begin
`ifdef GTXE2_RATE_DIV_ODD_EN
      return 1'b1;
`else
      return ~d[0];
`endif
    end
  endfunction

endpackage

// File: rtl/gtxe2_chnl_rate_div_ch.sv
// One divider channel: free-running period counter plus an IDLE/PEND handshake that
// swaps the divisor only on a period boundary. Legality follows GTXE2_RATE_DIV_ODD_EN.
module gtxe2_chnl_rate_div_ch
  import gtxe2_clk_pkg::*;
#(
  parameter int DIVW     = 5,
  parameter int DIV_INIT = 2
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [DIVW-1:0] div_in,
  input  logic            rate_req,
  output logic            rate_ack,
  output logic            busy,
  output logic            div_err,
  output logic            clk_out,
  output logic            ce_out
);

  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] div_cur;
  logic [DIVW-1:0] div_pend;
  div_state_t      state;

  logic            wrap;
  logic            apply;
  logic [DIVW-1:0] cnt_nxt;
  logic [DIVW-1:0] div_nxt;
  logic            clk_nxt;
  logic            req_ok;

  always_comb begin
    wrap    = (cnt == div_cur - DIVW'(1));
    apply   = (state == ST_PEND) && wrap;
    div_nxt = apply ? div_pend : div_cur;
    if (wrap) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + DIVW'(1);
    end
    // A fresh divisor always starts at cnt 0, so its first phase is complete.
    clk_nxt = (FW'(cnt_nxt) < hi_len(FW'(div_nxt)));
    req_ok  = div_legal(FW'(div_in));
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt      <= DIVW'(DIV_INIT - 1);
      div_cur  <= DIVW'(DIV_INIT);
      div_pend <= DIVW'(DIV_INIT);
      state    <= ST_IDLE;
      clk_out  <= 1'b0;
      ce_out   <= 1'b0;
      busy     <= 1'b0;
      rate_ack <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      div_cur  <= div_nxt;
      clk_out  <= clk_nxt;
      ce_out   <= (cnt_nxt == '0);
      rate_ack <= 1'b0;
      div_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rate_req) begin
            if (req_ok) begin
              div_pend <= div_in;
              state    <= ST_PEND;
              busy     <= 1'b1;
            end else begin
              div_err  <= 1'b1;
            end
          end
        end
        ST_PEND: begin
          // Requests arriving here are deliberately dropped.
          if (wrap) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            rate_ack <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gtxe2_chnl_rate_divider.sv
// NCH independent glitch-free clock dividers with a request/ack rate-change handshake.
// Odd divisors are enabled by defining GTXE2_RATE_DIV_ODD_EN.
module gtxe2_chnl_rate_divider
  import gtxe2_clk_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int DIVW     = 5,
  parameter int DIV_INIT = 2
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [NCH*DIVW-1:0] div_in,
  input  logic [NCH-1:0]      rate_req,
  output logic [NCH-1:0]      rate_ack,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      div_err,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      ce_out
);

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    gtxe2_chnl_rate_div_ch #(
      .DIVW    (DIVW),
      .DIV_INIT(DIV_INIT)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .div_in  (div_in[n*DIVW +: DIVW]),
      .rate_req(rate_req[n]),
      .rate_ack(rate_ack[n]),
      .busy    (busy[n]),
      .div_err (div_err[n]),
      .clk_out (clk_out[n]),
      .ce_out  (ce_out[n])
    );
  end

endmodule

// File: tb/tb_gtxe2_chnl_rate_divider.sv
// Bench for gtxe2_chnl_rate_divider: period-arithmetic reference model plus directed scenarios.
module tb_gtxe2_chnl_rate_divider;

  localparam int NCH      = 4;
  localparam int DIVW     = 5;
  localparam int DIV_INIT = 2;

  logic                clk_in   = 1'b0;
  logic                rst      = 1'b0;
  logic [NCH*DIVW-1:0] div_in   = '0;
  logic [NCH-1:0]      rate_req = '0;
  logic [NCH-1:0]      rate_ack, busy, div_err, clk_out, ce_out;

  gtxe2_chnl_rate_divider #(.NCH(NCH), .DIVW(DIVW), .DIV_INIT(DIV_INIT)) dut (
    .clk_in(clk_in), .rst(rst), .div_in(div_in), .rate_req(rate_req),
    .rate_ack(rate_ack), .busy(busy), .div_err(div_err),
    .clk_out(clk_out), .ce_out(ce_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  logic                smp_rst = 1'b1;
  logic [NCH-1:0]      smp_req = '0;
  logic [NCH*DIVW-1:0] smp_div = '0;

  always @(posedge clk_in) begin
    smp_rst <= rst;
    smp_req <= rate_req;
    smp_div <= div_in;
  end

  // Model: a period starts at edge t0 and lasts div edges; a pending change lands at edge b.
  int m_div [NCH];
  int m_k   [NCH];
  int m_t0  [NCH];
  int m_pdiv[NCH];
  int m_b   [NCH];
  bit m_pend[NCH];

  function automatic int hi(input int d);
`ifdef GTXE2_RATE_DIV_ODD_EN
    return (d + 1) / 2;
`else
    return d / 2;
`endif
  endfunction

  function automatic bit legal(input int d);
`ifdef GTXE2_RATE_DIV_ODD_EN
    return d >= 2;
`else
    return (d >= 2) && (d % 2 == 0);
`endif
  endfunction

  function automatic int mpos(input int ch);
    return (m_k[ch] - m_t0[ch]) % m_div[ch];
  endfunction

  task automatic chk(input string nm, input int ch, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s ch%0d: got %0d want %0d at %0t", nm, ch, act, exp, $time);
    end
  endtask

  always begin
    int pos, d;
    bit e_clk, e_ce, e_busy, e_ack, e_err;
    @(negedge clk_in);
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      e_clk = 0; e_ce = 0; e_busy = 0; e_ack = 0; e_err = 0;
      if (rst || smp_rst) begin
        m_div[ch]  = DIV_INIT;
        m_k[ch]    = -1;
        m_t0[ch]   = 0;
        m_pend[ch] = 0;
      end else begin
        m_k[ch]++;
        if (m_pend[ch] && m_k[ch] == m_b[ch]) begin
          m_div[ch]  = m_pdiv[ch];
          m_t0[ch]   = m_k[ch];
          m_pend[ch] = 0;
          e_ack      = 1;
        end else if (!m_pend[ch] && smp_req[ch]) begin
          d = int'(smp_div[ch*DIVW +: DIVW]);
          if (legal(d)) begin
            m_pend[ch] = 1;
            m_pdiv[ch] = d;
            m_b[ch]    = m_t0[ch] + ((m_k[ch] - m_t0[ch]) / m_div[ch] + 1) * m_div[ch];
          end else begin
            e_err = 1;
          end
        end
        pos    = mpos(ch);
        e_clk  = pos < hi(m_div[ch]);
        e_ce   = (pos == 0);
        e_busy = m_pend[ch];
      end
      chk("clk_out",  ch, int'(clk_out[ch]),  int'(e_clk));
      chk("ce_out",   ch, int'(ce_out[ch]),   int'(e_ce));
      chk("busy",     ch, int'(busy[ch]),     int'(e_busy));
      chk("rate_ack", ch, int'(rate_ack[ch]), int'(e_ack));
      chk("div_err",  ch, int'(div_err[ch]),  int'(e_err));
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #2;
  endtask

  task automatic set_req(input int ch, input int d);
    div_in[ch*DIVW +: DIVW] = DIVW'(d);
    rate_req[ch] = 1'b1;
  endtask

  task automatic wait_idle(input int ch);
    int n = 0;
    while (busy[ch] && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("idle_timeout", ch, n, 0);
  endtask

  task automatic wait_pos0(input int ch);
    int n = 0;
    while (mpos(ch) != 0 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("pos0_timeout", ch, n, 0);
  endtask

  initial begin
    int ce_n, tog, nb, na, per, h;
    logic prev;
    #2 rst = 1'b1;
    repeat (3) tick();
    chk("rst_outputs", 0, int'({clk_out, ce_out, busy, rate_ack, div_err}), 0);

    // Free run at DIV_INIT=2.
    rst = 1'b0;
    tick();
    chk("first_ce", 0, int'(ce_out), 15);
    chk("first_clk", 0, int'(clk_out), 15);
    ce_n = int'(ce_out[0]);
    tog  = 0;
    prev = clk_out[0];
    repeat (19) begin
      tick();
      ce_n += int'(ce_out[0]);
      if (clk_out[0] != prev) tog++;
      prev = clk_out[0];
    end
    chk("ce_count_20", 0, ce_n, 10);
    chk("clk_toggles_20", 0, tog, 19);

    // Channel 0 to div 4, then div 6 requested just after a boundary.
    set_req(0, 4); tick(); rate_req[0] = 1'b0;
    wait_idle(0);
    wait_pos0(0);
    set_req(0, 6); tick(); rate_req[0] = 1'b0;
    nb = 0;
    while (busy[0] && nb < 20) begin
      nb++;
      tick();
    end
    chk("busy_len", 0, nb, 3);
    chk("ack_on_wrap", 0, int'(rate_ack[0]), 1);
    chk("ce_on_ack", 0, int'(ce_out[0]), 1);
    per = 1;
    h   = int'(clk_out[0]);
    tick();
    while (!ce_out[0] && per < 20) begin
      per++;
      h += int'(clk_out[0]);
      tick();
    end
    chk("period_6", 0, per, 6);
    chk("high_3", 0, h, 3);

    // Illegal divisors on channel 1.
    set_req(1, 1); tick(); rate_req[1] = 1'b0;
    chk("err_div1", 1, int'(div_err[1]), 1);
    chk("nobusy_div1", 1, int'(busy[1]), 0);
    set_req(1, 0); tick(); rate_req[1] = 1'b0;
    chk("err_div0", 1, int'(div_err[1]), 1);
    set_req(1, 7); tick(); rate_req[1] = 1'b0;
`ifdef GTXE2_RATE_DIV_ODD_EN
    chk("busy_div7", 1, int'(busy[1]), 1);
    wait_idle(1);
    h = 0;
    repeat (7) begin
      h += int'(clk_out[1]);
      tick();
    end
    chk("high_div7", 1, h, 4);
`else
    chk("err_div7", 1, int'(div_err[1]), 1);
    chk("nobusy_div7", 1, int'(busy[1]), 0);
`endif

    // Second request while pending is ignored.
    wait_pos0(0);
    set_req(0, 8); tick();
    chk("busy_div8", 0, int'(busy[0]), 1);
    set_req(0, 10);
    na = 0;
    repeat (2) begin tick(); na += int'(rate_ack[0]); end
    rate_req[0] = 1'b0;
    repeat (12) begin tick(); na += int'(rate_ack[0]); end
    chk("single_ack", 0, na, 1);

    // Held request for the divisor already in use re-arms after each ack.
`ifdef GTXE2_RATE_DIV_ODD_EN
    set_req(1, 7);
`else
    set_req(1, 2);
`endif
    repeat (16) tick();
    rate_req[1] = 1'b0;
    wait_idle(1);
    wait_idle(0);

    // Simultaneous requests on all channels.
    set_req(0, 2); set_req(1, 3); set_req(2, 8); set_req(3, 31);
    tick();
    rate_req = '0;
    repeat (80) tick();

    // Reset while channel 2 is pending.
    set_req(2, 10); tick(); rate_req[2] = 1'b0;
    chk("busy_pre_rst", 2, int'(busy[2]), 1);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    na = 0; nb = 0; ce_n = 0;
    repeat (12) begin
      tick();
      na   += int'(rate_ack[2]);
      nb   += int'(busy[2]);
      ce_n += int'(ce_out[2]);
    end
    chk("no_ack_after_rst", 2, na, 0);
    chk("no_busy_after_rst", 2, nb, 0);
    chk("ce_after_rst", 2, ce_n, 6);

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gtxe2_chnl_rate_divider.md
GTXE2_CHNL_RATE_DIVIDER -- requirements
Module: gtxe2_chnl_rate_divider

Interface
REQ-001 Parameter NCH, default 2: number of independent divider channels, range 1..8.
REQ-002 Parameter DIVW, default 5: divisor width; legal divisors are 2..2^DIVW-1.
REQ-003 Parameter DIV_INIT, default 2: divisor loaded into every channel at reset; must be legal.
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 div_in  input  NCH*DIVW  requested divisor; channel n occupies bits [n*DIVW +: DIVW].
REQ-008 rate_req  input  NCH  per-channel rate-change request, sampled as a level.
REQ-009 rate_ack  output  NCH  one-cycle pulse when the new divisor takes effect.
REQ-010 busy  output  NCH  high while a captured request awaits its period boundary.
REQ-011 div_err  output  NCH  one-cycle pulse when a request is rejected as illegal.
REQ-012 clk_out  output  NCH  registered divided clock.
REQ-013 ce_out  output  NCH  one-cycle pulse coincident with each clk_out rising edge.

Function
REQ-014 Each channel SHALL hold a counter cnt in 0..div_cur-1 that increments every cycle and wraps to 0 after div_cur-1.
REQ-015 clk_out SHALL be registered high exactly when the updated cnt < hi_len, where hi_len = div_cur/2 for even divisors; the period is exactly div_cur cycles.
REQ-016 ce_out SHALL be high in exactly the cycle in which cnt becomes 0.
REQ-017 Each channel SHALL have a two-state FSM, IDLE and PEND.
REQ-018 In IDLE, rate_req high with a legal div_in SHALL capture div_in into div_pend and move to PEND; busy rises on the next cycle.
REQ-019 In IDLE, rate_req high with an illegal div_in (<2, or odd when REQ-029 applies) SHALL pulse div_err for one cycle, stay in IDLE and leave div_cur unchanged.
REQ-020 In PEND, at the cycle where cnt = div_cur-1:
  - div_cur <= div_pend, cnt <= 0
  - rate_ack pulses for one cycle
  - busy falls
  - FSM returns to IDLE
REQ-021 The new divisor SHALL therefore start on a period boundary, with no shortened or stretched high or low phase (glitch-free).
REQ-022 In PEND, rate_req SHALL be ignored: no capture and no div_err.
REQ-023 A held rate_req SHALL re-arm: the cycle after rate_ack, IDLE samples it again.
REQ-024 When a request is captured in the same cycle as a wrap (cnt = div_cur-1), the change SHALL apply at the following boundary, not the current one.
REQ-025 Worst-case latency from capture to rate_ack SHALL be div_cur cycles.
REQ-026 A request for the divisor already in use SHALL still complete the full handshake.
REQ-027 Channels SHALL be fully independent; simultaneous requests on all channels are legal.

Reset
REQ-028 While rst is high, per channel:
  - cnt = div_cur-1 with div_cur = DIV_INIT
  - FSM = IDLE
  - clk_out, ce_out, busy, rate_ack, div_err = 0
  - On the first edge after deassertion, cnt wraps to 0, so clk_out and ce_out go high.
  - Reset mid-PEND SHALL discard div_pend.

Configuration
REQ-029 Macro GTXE2_RATE_DIV_ODD_EN:
  - Defined: odd divisors are legal, with hi_len = (div_cur+1)/2; for example, div 5 gives 3 cycles high and 2 low.
  - Undefined: odd divisors are illegal and rejected per REQ-019.

Structure
REQ-030 Shared package gtxe2_clk_pkg SHALL hold:
  - the FSM state encoding (IDLE, PEND)
  - DIV_MIN = 2
  - the hi_len computation function
REQ-031 Per-channel logic SHALL be one sub-module, gtxe2_chnl_rate_div_ch, instantiated NCH times by generate.

Verification
REQ-032 Reset with DIV_INIT=2, free-run 20 cycles -> clk_out toggles every cycle; ce_out every 2nd cycle; first ce_out on the first edge after rst falls.
REQ-033 Channel 0 at div 4, request div 6 captured at cnt=1 -> busy for 3 cycles; rate_ack on the wrap edge; following periods exactly 6 cycles with 3 high; no runt pulse.
REQ-034 Request div 1, then div 0 -> div_err pulse each time, busy never rises, period unchanged; div 7 also gives div_err when the macro is undefined, and gives 4-high/3-low when defined.
REQ-035 Second request during PEND with a different value -> ignored; only the first value is applied; exactly one rate_ack.
REQ-036 NCH=4: simultaneous requests for divs 2, 3, 8, 31 (macro defined) -> each rate_ack lands on its own channel's boundary; other channels are undisturbed.
REQ-037 Assert rst while a channel is in PEND with div_pend=10 -> after release, div_cur = DIV_INIT, busy = 0, no rate_ack.
